hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage CPU. It covers the cases that EX-stage operand forwarding cannot resolve: load-use dependences (result comes from memory one stage too late), EX-stage control-flow redirects, and data-memory wait states. It produces the write-enables, flushes and bubble insertion for the PC, IF/ID, ID/EX and EX/MEM registers. It also keeps stall and flush performance counters.

## Interface
Parameters:
- FLUSH_LEN, 1: cycles the front end is squashed after a redirect (1..7).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- id_valid  in  1  ID stage holds a live instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source
- ex_valid  in  1  EX stage holds a live instruction
- ex_regwr  in  1  EX instruction writes the register file
- ex_regdst  in  2  EX write-back source, one of the RegDst_* codes
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- mem_busy  in  1  data memory not ready; MEM stage must hold
- pc_wr_en  out  1  PC may advance
- ifid_wr_en  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a bubble
- idex_bubble  out  1  ID/EX loads a bubble (valid=0, regwr=0)
- exmem_wr_en  out  1  EX/MEM may load
- stall_cycles  out  CNT_W  cycles with pc_wr_en=0
- flush_events  out  CNT_W  redirects applied

## Operation
- A load-use hazard (lu) exists when all of the following hold:
  - id_valid & ex_valid & ex_regwr & ex_regdst==RegDst_FromMEM & ex_rd!=0;
  - and either (id_use_rs1 & id_rs1==ex_rd) or (id_use_rs2 & id_rs2==ex_rd).
- Register x0 never creates a hazard.
- States:
  - RUN: normal operation.
  - FLUSH: front-end squash after a redirect.
  - MEM_WAIT: pipeline frozen on mem_busy.
- Priority each cycle: rst > mem_busy > redirect (ex_redirect or pending) > lu.
- RUN outputs:
  - No event: pc_wr_en=1, ifid_wr_en=1, exmem_wr_en=1, ifid_flush=0, idex_bubble=0.
  - lu: pc_wr_en=0, ifid_wr_en=0, idex_bubble=1, exmem_wr_en=1. A single bubble suffices, because the load then sits in MEM/WB where forwarding covers it.
  - ex_redirect: pc_wr_en=1 (target loads), ifid_flush=1, idex_bubble=1. Increment flush_events. Load flush_ctr=FLUSH_LEN-1. Go to FLUSH if FLUSH_LEN>1, else stay in RUN.
  - mem_busy: go to MEM_WAIT.
- FLUSH: ifid_flush=1, idex_bubble=1, pc_wr_en=1. Decrement flush_ctr; go to RUN when it reaches 0. mem_busy takes priority and is handled as in MEM_WAIT; the remaining flush count is preserved and resumed afterwards.
- MEM_WAIT: all write-enables=0, ifid_flush=0, idex_bubble=0 (freeze, not squash).
  - An ex_redirect seen while frozen sets redirect_pend.
  - On mem_busy=0: redirect_pend has priority. Apply the redirect as in RUN, clear redirect_pend, go to FLUSH or RUN.
  - Otherwise return to the state held before the wait.
- stall_cycles increments every cycle with pc_wr_en=0 outside reset.
- Both counters wrap modulo 2^CNT_W with no saturation.

## Timing
- Detection is combinational from the current inputs plus the registered state. There is no added latency: the stall or flush appears in the same cycle as the cause.
- State, flush_ctr, redirect_pend and the counters update on the rising clk edge.
- Reset (rst=1 at an edge):
  - state=RUN, flush_ctr=0, redirect_pend=0, counters=0.
  - While rst is high, outputs are pc_wr_en=0, ifid_wr_en=0, exmem_wr_en=0, ifid_flush=1, idex_bubble=1.
  - Reset mid-FLUSH or mid-MEM_WAIT discards all pending work.
- lu held for several cycles (e.g. upstream freeze) stalls for exactly as long as it holds. Nothing is latched.
- ex_redirect and lu in the same cycle: redirect wins, and the ID instruction is squashed anyway.

## Structure
- RegDst_FromALU/MEM/PC/CMP codes and the state encoding (RUN=0, FLUSH=1, MEM_WAIT=2) go in the shared define.v.
- Sub-module reg_match: inputs use, rs, rd, qualifier. Output = use & qual & rd!=0 & rs==rd. It is instantiated twice, once per source register.

## Test plan
- Load-use: ex_regdst=FromMEM, ex_rd=5, ex_regwr=1, id_rs1=5, id_use_rs1=1 → one cycle with pc_wr_en=0, ifid_wr_en=0, idex_bubble=1; stall_cycles=1; next cycle no stall.
- x0 and ALU source: ex_rd=0 with a matching rs, or ex_regdst=FromALU with rd=5 matching → no stall.
- Redirect with FLUSH_LEN=3: one ex_redirect pulse → ifid_flush=1 for 3 cycles; flush_events=1; pc_wr_en=1 throughout.
- Redirect during freeze: mem_busy=1 for 4 cycles, ex_redirect pulse in the 2nd → all enables 0 for 4 cycles, then the flush sequence runs; stall_cycles=4, flush_events=1.
- Reset mid-FLUSH: rst asserted during the 2nd flush cycle → counters 0, state RUN, no further flush after rst drops.
- Counter wrap: CNT_W=4 with 17 stall cycles → stall_cycles=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/stall controller: write-back source codes,
// controller state encoding and flush counter width.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RegDst_FromALU = 2'd0,
    RegDst_FromMEM = 2'd1,
    RegDst_FromPC  = 2'd2,
    RegDst_FromCMP = 2'd3
  } regdst_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  // Holds FLUSH_LEN-1 for FLUSH_LEN up to 7.
  localparam int FCTR_W = 3;

endpackage

// File: rtl/hazard_ctrl_reg_match.sv
// Source/destination register comparator for load-use detection.
// x0 never matches.
module reg_match (
  input  logic       use_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_i,
  input  logic       qual_i,
  output logic       match_o
);

  assign match_o = use_i & qual_i & (rd_i != 5'd0) & (rs_i == rd_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, redirect squash,
// data-memory freeze, plus stall and flush performance counters.
module hazard_ctrl #(
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_regwr,
  input  logic [1:0]       ex_regdst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_wr_en,
  output logic             ifid_wr_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_wr_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  import hazard_ctrl_pkg::*;

  localparam logic [FCTR_W-1:0] FLUSH_INIT = FCTR_W'(FLUSH_LEN - 1);

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  state_e              eff_state;
  logic [FCTR_W-1:0]   fctr_q, fctr_d;
  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    stall_q, flush_q;
  logic                qual, m1, m2, lu, redir, apply_redir;

  assign qual = id_valid & ex_valid & ex_regwr & (ex_regdst == RegDst_FromMEM);

  reg_match u_match_rs1 (
    .use_i   (id_use_rs1),
    .rs_i    (id_rs1),
    .rd_i    (ex_rd),
    .qual_i  (qual),
    .match_o (m1)
  );

  reg_match u_match_rs2 (
    .use_i   (id_use_rs2),
    .rs_i    (id_rs2),
    .rd_i    (ex_rd),
    .qual_i  (qual),
    .match_o (m2)
  );

  assign lu = m1 | m2;

  // Once memory releases, MEM_WAIT behaves exactly like the state it interrupted.
  assign eff_state   = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
  assign redir       = ex_redirect | pend_q;
  assign apply_redir = ~mem_busy & redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      fctr_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fctr_q  <= fctr_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    fctr_d  = fctr_q;
    pend_d  = pend_q;
    if (mem_busy) begin
      state_d = ST_MEM_WAIT;
      ret_d   = eff_state;
      pend_d  = pend_q | ex_redirect;
    end else if (redir) begin
      pend_d  = 1'b0;
      fctr_d  = FLUSH_INIT;
      state_d = (FLUSH_LEN > 1) ? ST_FLUSH : ST_RUN;
    end else if (eff_state == ST_FLUSH) begin
      fctr_d  = fctr_q - FCTR_W'(1);
      state_d = (fctr_q <= FCTR_W'(1)) ? ST_RUN : ST_FLUSH;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    pc_wr_en    = 1'b1;
    ifid_wr_en  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_wr_en = 1'b1;
    if (rst) begin
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      exmem_wr_en = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      exmem_wr_en = 1'b0;
    end else if (redir || eff_state == ST_FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      // One bubble is enough: the load then sits in MEM/WB and forwarding covers it.
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_wr_en)
        stall_q <= stall_q + CNT_W'(1);
      if (apply_redir)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int FLUSH_LEN = 3;
  localparam int CNT_W     = 4;

  // {pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, exmem_wr_en}
  localparam logic [4:0] NORM = 5'b11001;
  localparam logic [4:0] LU   = 5'b00011;
  localparam logic [4:0] RED  = 5'b11111;
  localparam logic [4:0] FRZ  = 5'b00000;
  localparam logic [4:0] RST  = 5'b00110;

  logic             clk, rst;
  logic             id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_valid, ex_regwr, ex_redirect, mem_busy;
  logic [1:0]       ex_regdst;
  logic             pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, exmem_wr_en;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  typedef struct {
    string      nm;
    logic [4:0] outv;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  hazard_ctrl #(.FLUSH_LEN(FLUSH_LEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_valid     (ex_valid),
    .ex_regwr     (ex_regwr),
    .ex_regdst    (ex_regdst),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .pc_wr_en     (pc_wr_en),
    .ifid_wr_en   (ifid_wr_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_wr_en  (exmem_wr_en),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet();
    id_valid    = 1'b0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_valid    = 1'b0;
    ex_regwr    = 1'b0;
    ex_regdst   = RegDst_FromALU;
    ex_rd       = 5'd0;
    ex_redirect = 1'b0;
    mem_busy    = 1'b0;
  endtask

  task automatic lu_set();
    quiet();
    id_valid   = 1'b1;
    id_rs1     = 5'd5;
    id_use_rs1 = 1'b1;
    ex_valid   = 1'b1;
    ex_regwr   = 1'b1;
    ex_regdst  = RegDst_FromMEM;
    ex_rd      = 5'd5;
  endtask

  // Inputs are already applied; record what this cycle must show, then advance.
  task automatic step(input string nm, input logic [4:0] ov, input int st, input int fl);
    exp_t e;
    e.nm    = nm;
    e.outv  = ov;
    e.stall = st;
    e.flush = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t       e;
    logic [4:0] got;
    logic [CNT_W-1:0] es, ef;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, exmem_wr_en};
        es  = e.stall[CNT_W-1:0];
        ef  = e.flush[CNT_W-1:0];
        n_chk++;
        if (got !== e.outv) begin
          n_fail++;
          $display("FAIL %s outputs: got %b want %b", e.nm, got, e.outv);
        end
        n_chk++;
        if (stall_cycles !== es || flush_events !== ef) begin
          n_fail++;
          $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   e.nm, stall_cycles, flush_events, es, ef);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    quiet();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("rst0", RST, 0, 0);
    step("rst1", RST, 0, 0);
    rst = 1'b0;
    step("idle", NORM, 0, 0);

    lu_set();                                 step("lu_rs1", LU, 0, 0);
    quiet();                                  step("lu_gone", NORM, 1, 0);
    lu_set(); id_rs1 = 5'd3; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
                                              step("lu_rs2", LU, 1, 0);
    quiet();                                  step("after_rs2", NORM, 2, 0);
    lu_set(); id_use_rs1 = 1'b0;              step("use_off", NORM, 2, 0);
    lu_set(); ex_rd = 5'd0; id_rs1 = 5'd0;    step("x0", NORM, 2, 0);
    lu_set(); ex_regdst = RegDst_FromALU;     step("alu_src", NORM, 2, 0);
    lu_set(); ex_valid = 1'b0;                step("ex_invalid", NORM, 2, 0);
    lu_set(); ex_regwr = 1'b0;                step("no_regwr", NORM, 2, 0);
    lu_set(); id_valid = 1'b0;                step("id_invalid", NORM, 2, 0);
    lu_set();
    for (int i = 0; i < 3; i++) step("lu_hold", LU, 2 + i, 0);
    quiet();                                  step("hold_end", NORM, 5, 0);

    // redirect beats a simultaneous load-use; FLUSH_LEN=3 squashes three cycles
    lu_set(); ex_redirect = 1'b1;             step("redir_lu", RED, 5, 0);
    quiet();                                  step("flush2", RED, 5, 1);
                                              step("flush3", RED, 5, 1);
                                              step("flush_done", NORM, 5, 1);

    // redirect arriving while memory holds the pipeline
    mem_busy = 1'b1;                          step("frz1", FRZ, 5, 1);
    ex_redirect = 1'b1;                       step("frz2", FRZ, 6, 1);
    ex_redirect = 1'b0;                       step("frz3", FRZ, 7, 1);
                                              step("frz4", FRZ, 8, 1);
    mem_busy = 1'b0;                          step("pend_apply", RED, 9, 1);
                                              step("pend_fl2", RED, 9, 2);
                                              step("pend_fl3", RED, 9, 2);
                                              step("pend_done", NORM, 9, 2);

    // memory wait in the middle of a flush keeps the remaining count
    ex_redirect = 1'b1;                       step("redir_b", RED, 9, 2);
    ex_redirect = 1'b0;                       step("fb1", RED, 9, 3);
    mem_busy = 1'b1;                          step("fb_frz1", FRZ, 9, 3);
                                              step("fb_frz2", FRZ, 10, 3);
    mem_busy = 1'b0;                          step("fb_resume", RED, 11, 3);
                                              step("fb_done", NORM, 11, 3);

    // reset during the second flush cycle
    ex_redirect = 1'b1;                       step("redir_r", RED, 11, 3);
    ex_redirect = 1'b0; rst = 1'b1;           step("rst_mid", RST, 11, 4);
    rst = 1'b0;                               step("post_rst", NORM, 0, 0);
                                              step("post_rst2", NORM, 0, 0);

    // reset during a wait discards a pending redirect
    mem_busy = 1'b1; ex_redirect = 1'b1;      step("wait_pend", FRZ, 0, 0);
    mem_busy = 1'b0; ex_redirect = 1'b0; rst = 1'b1;
                                              step("rst_wait", RST, 1, 0);
    rst = 1'b0;                               step("no_pend", NORM, 0, 0);

    // 17 stall cycles on a 4-bit counter
    lu_set();
    for (int i = 0; i < 17; i++) step("wrap", LU, i % 16, 0);
    quiet();                                  step("wrapped", NORM, 1, 0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
